aes_ecb_sched: RTL and testbench

Scheduler that shares one 128-bit AES-ECB engine between an encrypt requester and a decrypt requester. Each request carries a 128-bit key and a 256-bit payload. The block splits the payload into two 128-bit ECB blocks (high half first), runs each through the engine with a start/done handshake, and reassembles the 256-bit result. It returns that result on the requester's own response channel. It sits between the encrypt/decrypt stream logic and the shared engine (RTL core or pyvpi-backed model), and adds round-robin arbitration, a watchdog timeout and rejection of null requests.

---
 rtl/aes_ecb_sched.sv | 160 ++++++++++++++++
 tb/tb_aes_ecb_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ecb_sched.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : aes_ecb_sched
// Desc     : Round-robin share of one 128-bit AES-ECB engine between encrypt
//            and decrypt requesters, 256-bit payloads split into two blocks.
// Revision : 1.0
//============================================================================
module aes_ecb_sched #(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enc_valid,
    output logic         enc_ready,
    input  logic [127:0] enc_key,
    input  logic [255:0] enc_text,
    output logic         enc_rsp_valid,
    input  logic         enc_rsp_ready,
    output logic [255:0] enc_rsp_data,
    output logic         enc_rsp_err,
    input  logic         dec_valid,
    output logic         dec_ready,
    input  logic [127:0] dec_key,
    input  logic [255:0] dec_text,
    output logic         dec_rsp_valid,
    input  logic         dec_rsp_ready,
    output logic [255:0] dec_rsp_data,
    output logic         dec_rsp_err,
    output logic         eng_start,
    output logic         eng_mode,
    output logic [127:0] eng_key,
    output logic [127:0] eng_din,
    input  logic         eng_done,
    input  logic [127:0] eng_dout,
    output logic         busy
);

    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_ISSUE_HI = 3'd1;
    localparam logic [2:0] c_WAIT_HI  = 3'd2;
    localparam logic [2:0] c_ISSUE_LO = 3'd3;
    localparam logic [2:0] c_WAIT_LO  = 3'd4;
    localparam logic [2:0] c_RESP     = 3'd5;

    localparam logic c_ENC = 1'b0;
    localparam logic c_DEC = 1'b1;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic               r_last_grant;
    logic               r_owner;
    logic               r_err;
    logic [127:0]       r_key;
    logic [255:0]       r_text;
    logic [255:0]       r_result;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_enc_acc;
    logic w_dec_acc;
    logic w_acc;
    logic w_null;
    logic w_in_wait;
    logic w_timeout;
    logic w_rsp_hs;

    assign w_enc_acc = enc_valid && enc_ready;
    assign w_dec_acc = dec_valid && dec_ready;
    assign w_acc     = w_enc_acc || w_dec_acc;
    assign w_null    = w_enc_acc ? ((enc_key == '0) || (enc_text == '0))
                                 : ((dec_key == '0) || (dec_text == '0));
    assign w_in_wait = (r_state == c_WAIT_HI) || (r_state == c_WAIT_LO);
    // A done arriving in the expiry cycle takes priority over the watchdog.
    assign w_timeout = (TIMEOUT != 0) && w_in_wait && !eng_done &&
                       (r_cnt == c_CNT_W'(TIMEOUT - 1));
    assign w_rsp_hs  = (r_state == c_RESP) &&
                       ((r_owner == c_ENC) ? enc_rsp_ready : dec_rsp_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:     if (w_acc) w_next = w_null ? c_RESP : c_ISSUE_HI;
            c_ISSUE_HI: w_next = c_WAIT_HI;
            c_WAIT_HI:  if (eng_done) w_next = c_ISSUE_LO;
                        else if (w_timeout) w_next = c_RESP;
            c_ISSUE_LO: w_next = c_WAIT_LO;
            c_WAIT_LO:  if (eng_done || w_timeout) w_next = c_RESP;
            c_RESP:     if (w_rsp_hs) w_next = c_IDLE;
            default:    w_next = c_IDLE;
        endcase
    end

    always_comb begin
        enc_ready     = (r_state == c_IDLE) && (!dec_valid || (r_last_grant == c_DEC));
        dec_ready     = (r_state == c_IDLE) && (!enc_valid || (r_last_grant == c_ENC));
        eng_start     = (r_state == c_ISSUE_HI) || (r_state == c_ISSUE_LO);
        eng_din       = ((r_state == c_ISSUE_LO) || (r_state == c_WAIT_LO)) ?
                        r_text[127:0] : r_text[255:128];
        enc_rsp_valid = (r_state == c_RESP) && (r_owner == c_ENC);
        dec_rsp_valid = (r_state == c_RESP) && (r_owner == c_DEC);
        busy          = (r_state != c_IDLE);
    end

    assign eng_mode     = r_owner;
    assign eng_key      = r_key;
    assign enc_rsp_data = r_result;
    assign dec_rsp_data = r_result;
    assign enc_rsp_err  = r_err;
    assign dec_rsp_err  = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= c_DEC;
            r_owner      <= c_ENC;
            r_err        <= 1'b0;
            r_key        <= '0;
            r_text       <= '0;
            r_result     <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_acc) begin
                        r_owner      <= w_enc_acc ? c_ENC : c_DEC;
                        r_last_grant <= w_enc_acc ? c_ENC : c_DEC;
                        r_key        <= w_enc_acc ? enc_key : dec_key;
                        r_text       <= w_enc_acc ? enc_text : dec_text;
                        r_result     <= '0;
                        r_err        <= w_null;
                    end
                end
                c_ISSUE_HI, c_ISSUE_LO: r_cnt <= '0;
                c_WAIT_HI, c_WAIT_LO: begin
                    if (eng_done) begin
                        if (r_state == c_WAIT_HI) r_result[255:128] <= eng_dout;
                        else                      r_result[127:0]   <= eng_dout;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_ecb_sched.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for aes_ecb_sched with a table-lookup/XOR engine stub.
module tb_aes_ecb_sched;

    localparam logic [127:0] c_NKEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_PT_HI = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] c_PT_LO = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] c_CT_HI = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] c_CT_LO = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] c_KA    = 128'h11111111111111111111111111111111;
    localparam logic [255:0] c_TA    = {128'h22222222222222222222222222222222, 128'h44444444444444444444444444444444};
    localparam logic [255:0] c_EA    = {128'h33333333333333333333333333333333, 128'h55555555555555555555555555555555};
    localparam logic [127:0] c_KB    = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [255:0] c_TB    = {128'h0123456789abcdef0123456789abcdef, 128'h0};
    localparam logic [255:0] c_EB    = {128'hfedcba9876543210fedcba9876543210, 128'hffffffffffffffffffffffffffffffff};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enc_valid = 1'b0, enc_ready, enc_rsp_valid, enc_rsp_ready = 1'b0, enc_rsp_err;
    logic [127:0] enc_key = '0;
    logic [255:0] enc_text = '0, enc_rsp_data;
    logic         dec_valid = 1'b0, dec_ready, dec_rsp_valid, dec_rsp_ready = 1'b0, dec_rsp_err;
    logic [127:0] dec_key = '0;
    logic [255:0] dec_text = '0, dec_rsp_data;
    logic         eng_start, eng_mode, eng_done, busy;
    logic [127:0] eng_key, eng_din, eng_dout;

    aes_ecb_sched #(.TIMEOUT(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_key(enc_key), .enc_text(enc_text),
        .enc_rsp_valid(enc_rsp_valid), .enc_rsp_ready(enc_rsp_ready),
        .enc_rsp_data(enc_rsp_data), .enc_rsp_err(enc_rsp_err),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_key(dec_key), .dec_text(dec_text),
        .dec_rsp_valid(dec_rsp_valid), .dec_rsp_ready(dec_rsp_ready),
        .dec_rsp_data(dec_rsp_data), .dec_rsp_err(dec_rsp_err),
        .eng_start(eng_start), .eng_mode(eng_mode), .eng_key(eng_key), .eng_din(eng_din),
        .eng_done(eng_done), .eng_dout(eng_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int errors = 0;
    int checks = 0;

    // Engine stub: NIST vectors for the NIST key, otherwise din^key; lat 0 = never answers.
    int           eng_lat = 1;
    int           eng_cnt = 0;
    int           n_starts = 0;
    int           start_cyc [2];
    logic         start_mode [2];
    logic [127:0] eng_res = '0;

    function automatic logic [127:0] eng_f(input logic [127:0] din, input logic [127:0] key, input logic mode);
        logic [127:0] r;
        r = din ^ key;
        if (key == c_NKEY) begin
            if (!mode && din == c_PT_HI) r = c_CT_HI;
            if (!mode && din == c_PT_LO) r = c_CT_LO;
            if (mode && din == c_CT_HI)  r = c_PT_HI;
            if (mode && din == c_CT_LO)  r = c_PT_LO;
        end
        return r;
    endfunction

    initial begin
        eng_done = 1'b0;
        eng_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (!rst_n) begin
                eng_cnt = 0;
            end else begin
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        eng_done = 1'b1;
                        eng_dout = eng_res;
                    end
                end
                if (eng_start) begin
                    if (n_starts < 2) begin
                        start_cyc[n_starts]  = cycle;
                        start_mode[n_starts] = eng_mode;
                    end
                    n_starts++;
                    eng_res = eng_f(eng_din, eng_key, eng_mode);
                    eng_cnt = eng_lat;
                end
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic ch, input logic [127:0] k, input logic [255:0] t,
                        output int t_acc, output bit ok);
        @(posedge clk);
        #1;
        if (!ch) begin enc_valid = 1'b1; enc_key = k; enc_text = t; end
        else     begin dec_valid = 1'b1; dec_key = k; dec_text = t; end
        ok = 1'b0;
        t_acc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((!ch && enc_ready) || (ch && dec_ready)) begin
                ok = 1'b1;
                t_acc = cycle;
                break;
            end
        end
        @(posedge clk);
        #1;
        // Scramble inputs after accept: the block must work from its captured copy.
        if (!ch) begin enc_valid = 1'b0; enc_key = ~k; enc_text = ~t; end
        else     begin dec_valid = 1'b0; dec_key = ~k; dec_text = ~t; end
        if (!ok) check("accept_wait", 256'(0), 256'(1));
    endtask

    task automatic wait_rsp(input logic ch, output int t_rsp, output bit ok);
        ok = 1'b0;
        t_rsp = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((!ch && enc_rsp_valid) || (ch && dec_rsp_valid)) begin
                ok = 1'b1;
                t_rsp = cycle;
                break;
            end
        end
        if (!ok) check("rsp_wait", 256'(0), 256'(1));
    endtask

    task automatic handshake(input logic ch);
        if (!ch) enc_rsp_ready = 1'b1;
        else     dec_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        enc_rsp_ready = 1'b0;
        dec_rsp_ready = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic ch, input logic [127:0] k, input logic [255:0] t,
                           input int lat, input logic [255:0] exp_d, input logic exp_e,
                           input int exp_lat, input int exp_starts, output int t_acc, output int t_rsp);
        bit ok;
        eng_lat  = lat;
        n_starts = 0;
        t_rsp    = 0;
        send(ch, k, t, t_acc, ok);
        if (ok) begin
            wait_rsp(ch, t_rsp, ok);
            if (ok) begin
                check({tag, "_lat"}, 256'(t_rsp - t_acc), 256'(exp_lat));
                check({tag, "_data"}, ch ? dec_rsp_data : enc_rsp_data, exp_d);
                check({tag, "_err"}, 256'(ch ? dec_rsp_err : enc_rsp_err), 256'(exp_e));
                check({tag, "_other"}, 256'(ch ? enc_rsp_valid : dec_rsp_valid), 256'(0));
                check({tag, "_starts"}, 256'(n_starts), 256'(exp_starts));
                for (int j = 0; j < 2; j++)
                    if (j < exp_starts) check({tag, "_mode"}, 256'(start_mode[j]), 256'(ch));
                handshake(ch);
                @(negedge clk);
                check({tag, "_idle"}, 256'(busy), 256'(0));
            end
        end
    endtask

    typedef struct {
        string        tag;
        logic         ch;
        logic [127:0] key;
        logic [255:0] text;
        int           lat;
        logic [255:0] exp_data;
        logic         exp_err;
        int           exp_lat;
        int           exp_starts;
    } vec_t;

    vec_t vecs [6];

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctrl"}, 256'({busy, eng_start, enc_rsp_valid, dec_rsp_valid,
                                    enc_rsp_err, dec_rsp_err, eng_mode}), 256'(0));
        check({tag, "_din"}, 256'(eng_din), 256'(0));
        check({tag, "_key"}, 256'(eng_key), 256'(0));
        check({tag, "_data"}, enc_rsp_data | dec_rsp_data, 256'(0));
    endtask

    initial begin
        int   t_acc, t_rsp, ne, nd;
        bit   ok;
        logic owner, exp_owner;

        vecs[0] = '{"nist_enc", 1'b0, c_NKEY, {c_PT_HI, c_PT_LO}, 1, {c_CT_HI, c_CT_LO}, 1'b0, 5, 2};
        vecs[1] = '{"nist_dec", 1'b1, c_NKEY, {c_CT_HI, c_CT_LO}, 1, {c_PT_HI, c_PT_LO}, 1'b0, 5, 2};
        vecs[2] = '{"null_key", 1'b0, 128'h0, {c_PT_HI, c_PT_LO}, 1, 256'h0, 1'b1, 1, 0};
        vecs[3] = '{"null_text", 1'b1, c_KA, 256'h0, 1, 256'h0, 1'b1, 1, 0};
        vecs[4] = '{"enc_lat3", 1'b0, c_KB, c_TB, 3, c_EB, 1'b0, 9, 2};
        vecs[5] = '{"dec_lat2", 1'b1, c_KA, c_TA, 2, c_EA, 1'b0, 7, 2};

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Arbitration: both requesters valid; grants must alternate starting with encrypt.
        eng_lat = 1;
        @(posedge clk);
        #1;
        enc_valid = 1'b1; enc_key = c_KA; enc_text = c_TA;
        dec_valid = 1'b1; dec_key = c_KB; dec_text = c_TB;
        exp_owner = 1'b0;
        ne = 0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            ok = 1'b0;
            for (int w = 0; w < 50; w++) begin
                @(negedge clk);
                if (enc_ready || dec_ready) begin ok = 1'b1; break; end
            end
            check("arb_grant", 256'({enc_ready, dec_ready}), exp_owner ? 256'(1) : 256'(2));
            owner = dec_ready;
            @(posedge clk);
            #1;
            if (!owner) begin ne++; if (ne == 3) enc_valid = 1'b0; end
            else        begin nd++; if (nd == 3) dec_valid = 1'b0; end
            wait_rsp(owner, t_rsp, ok);
            check("arb_other_rsp", 256'(owner ? enc_rsp_valid : dec_rsp_valid), 256'(0));
            check("arb_data", owner ? dec_rsp_data : enc_rsp_data, owner ? c_EB : c_EA);
            handshake(owner);
            exp_owner = ~exp_owner;
        end
        enc_valid = 1'b0;
        dec_valid = 1'b0;

        for (int v = 0; v < 6; v++)
            run_one(vecs[v].tag, vecs[v].ch, vecs[v].key, vecs[v].text, vecs[v].lat,
                    vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_lat, vecs[v].exp_starts, t_acc, t_rsp);

        // Watchdog: engine silent, then engine answering on the last allowed wait cycle.
        run_one("timeout", 1'b0, c_KA, c_TA, 0, 256'h0, 1'b1, 10, 1, t_acc, t_rsp);
        check("timeout_gap", 256'(t_rsp - start_cyc[0]), 256'(9));
        run_one("done_at_limit", 1'b1, c_KA, c_TA, 8, c_EA, 1'b0, 19, 2, t_acc, t_rsp);

        // Backpressure: response held while both requesters push.
        eng_lat  = 1;
        n_starts = 0;
        send(1'b0, c_NKEY, {c_PT_HI, c_PT_LO}, t_acc, ok);
        wait_rsp(1'b0, t_rsp, ok);
        enc_valid = 1'b1; enc_key = c_KA; enc_text = c_TA;
        dec_valid = 1'b1; dec_key = c_KB; dec_text = c_TB;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_data", enc_rsp_data, {c_CT_HI, c_CT_LO});
            check("bp_hold", 256'({enc_rsp_valid, enc_ready, dec_ready, dec_rsp_valid}), 256'(8));
        end
        enc_valid = 1'b0;
        dec_valid = 1'b0;
        handshake(1'b0);

        // Reset while the low block is outstanding.
        eng_lat  = 3;
        n_starts = 0;
        send(1'b0, c_NKEY, {c_PT_HI, c_PT_LO}, t_acc, ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (n_starts == 2 && !eng_start) begin ok = 1'b1; break; end
        end
        check("rst_reach_wait_lo", 256'({ok, busy}), 256'(3));
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        @(negedge clk);
        check_zero_outputs("midrst_hold");
        rst_n = 1'b1;
        run_one("after_rst", 1'b0, c_NKEY, {c_PT_HI, c_PT_LO}, 1, {c_CT_HI, c_CT_LO}, 1'b0, 5, 2, t_acc, t_rsp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
